// File: rtl/lcd_write_sequencer.sv
// HD44780-style byte write sequencer: setup, enable pulse, hold and execution
// wait are all measured in ticks from the external 4 us timer.
module lcd_write_sequencer #(
   parameter int SETUP_TICKS     = 1,
   parameter int E_TICKS         = 2,
   parameter int HOLD_TICKS      = 1,
   parameter int EXEC_TICKS      = 10,
   parameter int LONG_EXEC_TICKS = 410,
   parameter int CNT_W           = 10
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       ReqValid,
   input  logic       ReqRS,
   input  logic [7:0] ReqData,
   output logic       ReqReady,
   input  logic       Abort,
   input  logic       TimerTick,
   output logic       EnableCount,
   output logic       DisableCount,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [7:0] LCD_DATA,
   output logic       Done
);

   // state | meaning
   // IDLE  | waiting for a request, timer stopped
   // SETUP | RS/DB driven, E low
   // EHIGH | E high
   // HOLD  | E low again, RS/DB still held
   // EXEC  | LCD executing the write
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      EHIGH = 3'd2,
      HOLD  = 3'd3,
      EXEC  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_TICKS - 1);
   localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_TICKS - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);
   localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_TICKS - 1);
   localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_EXEC_TICKS - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             is_long;
   logic [CNT_W-1:0] cnt_last;

   assign LCD_RW = 1'b0;

   always_comb begin
      cnt_last = '0;
      case (state)
         SETUP:   cnt_last = SETUP_LAST;
         EHIGH:   cnt_last = E_LAST;
         HOLD:    cnt_last = HOLD_LAST;
         EXEC:    cnt_last = is_long ? LONG_LAST : EXEC_LAST;
         default: cnt_last = '0;
      endcase
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         is_long      <= 1'b0;
         ReqReady     <= 1'b1;
         EnableCount  <= 1'b0;
         DisableCount <= 1'b0;
         LCD_E        <= 1'b0;
         LCD_RS       <= 1'b0;
         LCD_DATA     <= 8'h00;
         Done         <= 1'b0;
      end else begin
         Done         <= 1'b0;
         DisableCount <= 1'b0;
         case (state)
            IDLE: begin
               // Abort in IDLE only suppresses acceptance for that cycle
               if (ReqValid && ReqReady && !Abort) begin
                  state       <= SETUP;
                  cnt         <= '0;
                  LCD_RS      <= ReqRS;
                  LCD_DATA    <= ReqData;
                  is_long     <= !ReqRS && (ReqData inside {8'h01, 8'h02, 8'h03});
                  ReqReady    <= 1'b0;
                  EnableCount <= 1'b1;
               end
            end
            SETUP, EHIGH, HOLD, EXEC: begin
               if (Abort) begin
                  state        <= IDLE;
                  cnt          <= '0;
                  LCD_E        <= 1'b0;
                  DisableCount <= 1'b1;
                  ReqReady     <= 1'b1;
                  EnableCount  <= 1'b0;
               end else if (TimerTick) begin
                  if (cnt == cnt_last) begin
                     cnt <= '0;
                     case (state)
                        SETUP: begin
                           state <= EHIGH;
                           LCD_E <= 1'b1;
                        end
                        EHIGH: begin
                           state <= HOLD;
                           LCD_E <= 1'b0;
                        end
                        HOLD:  state <= EXEC;
                        default: begin
                           state        <= IDLE;
                           Done         <= 1'b1;
                           DisableCount <= 1'b1;
                           ReqReady     <= 1'b1;
                           EnableCount  <= 1'b0;
                        end
                     endcase
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state       <= IDLE;
               cnt         <= '0;
               LCD_E       <= 1'b0;
               ReqReady    <= 1'b1;
               EnableCount <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: a tick-count reference model predicts every
// output each cycle under directed and randomized request/tick/abort traffic.
module tb_lcd_write_sequencer;

   localparam int S  = 1;
   localparam int E  = 2;
   localparam int H  = 1;
   localparam int EX = 10;
   localparam int LX = 410;

   logic       clock = 1'b0;
   logic       rst;
   logic       ReqValid, ReqRS, Abort, TimerTick;
   logic [7:0] ReqData;
   logic       ReqReady, EnableCount, DisableCount, LCD_E, LCD_RS, LCD_RW, Done;
   logic [7:0] LCD_DATA;
   logic [14:0] obs;

   int n_tests = 0;
   int n_fail  = 0;
   int n_done, n_epulse, n_dis, wt, last_wt;
   logic prev_e = 1'b0;

   // reference model: a write is just "busy for t ticks out of a known total"
   logic       m_busy = 1'b0, m_rs = 1'b0, m_long = 1'b0, m_dis = 1'b0, m_done = 1'b0, m_acc = 1'b0;
   logic [7:0] m_data = 8'h00;
   int         m_t = 0;
   logic [8:0] q[$];

   always #5 clock = ~clock;

   lcd_write_sequencer dut (
      .clock(clock), .rst(rst), .ReqValid(ReqValid), .ReqRS(ReqRS), .ReqData(ReqData),
      .ReqReady(ReqReady), .Abort(Abort), .TimerTick(TimerTick), .EnableCount(EnableCount),
      .DisableCount(DisableCount), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
      .LCD_DATA(LCD_DATA), .Done(Done)
   );

   assign obs = {ReqReady, EnableCount, DisableCount, LCD_E, LCD_RS, LCD_RW, LCD_DATA, Done};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int total_ticks();
      return S + E + H + (m_long ? LX : EX);
   endfunction

   function automatic logic [14:0] exp_vec();
      logic e_hi;
      e_hi = m_busy && (m_t >= S) && (m_t < S + E);
      return {!m_busy, m_busy, m_dis, e_hi, m_rs, 1'b0, m_data, m_done};
   endfunction

   task automatic model_step(input logic v, input logic rs, input logic [7:0] d,
                             input logic ab, input logic tk);
      m_dis = 1'b0; m_done = 1'b0; m_acc = 1'b0;
      if (!m_busy) begin
         if (v && !ab) begin
            m_busy = 1'b1; m_t = 0; m_rs = rs; m_data = d; m_acc = 1'b1;
            m_long = !rs && (d >= 8'h01) && (d <= 8'h03);
         end
      end else if (ab) begin
         m_busy = 1'b0; m_t = 0; m_dis = 1'b1;
      end else if (tk) begin
         m_t++;
         if (m_t == total_ticks()) begin
            m_busy = 1'b0; m_done = 1'b1; m_dis = 1'b1;
         end
      end
   endtask

   task automatic cycle(input logic v, input logic rs, input logic [7:0] d,
                        input logic ab, input logic tk, input string tag);
      logic was_busy;
      was_busy = m_busy;
      ReqValid = v; ReqRS = rs; ReqData = d; Abort = ab; TimerTick = tk;
      model_step(v, rs, d, ab, tk);
      @(posedge clock);
      @(negedge clock);
      chk(tag, 32'(obs), 32'(exp_vec()));
      if (was_busy && tk) wt++;
      if (m_acc) wt = 0;
      if (Done) begin n_done++; last_wt = wt; end
      if (DisableCount) n_dis++;
      if (LCD_E && !prev_e) n_epulse++;
      prev_e = LCD_E;
   endtask

   // mode 0: plain, 1: abort once while E is high, 2: stray request once in EXEC
   task automatic run(input int per, input int mode, input int budget, input string tag);
      int   cyc;
      logic tk, ab, inj, fired;
      cyc = 0; fired = 1'b0;
      n_done = 0; n_epulse = 0; n_dis = 0; last_wt = -1;
      while ((q.size() > 0 || m_busy) && cyc < budget) begin
         tk  = (per == 0) ? 1'($urandom_range(0, 1)) : ((cyc % per) == per - 1);
         ab  = (mode == 1) && !fired && m_busy && (m_t >= S) && (m_t < S + E);
         inj = (mode == 2) && !fired && m_busy && (m_t >= S + E + H);
         if (ab || inj) fired = 1'b1;
         if (inj)
            cycle(1'b1, 1'b0, 8'h01, 1'b0, tk, tag);
         else if (q.size() > 0)
            cycle(1'b1, q[0][8], q[0][7:0], ab, tk, tag);
         else
            cycle(1'b0, 1'b0, 8'h00, ab, tk, tag);
         if (m_acc && !inj) void'(q.pop_front());
         cyc++;
      end
      chk({tag, "_in_budget"}, 32'(cyc < budget), 32'd1);
   endtask

   initial begin
      logic [7:0] lens[3];
      int cyc;
      rst = 1'b0; ReqValid = 1'b0; ReqRS = 1'b0; ReqData = 8'h00; Abort = 1'b0; TimerTick = 1'b0;
      @(negedge clock);
      chk("reset_outputs", 32'(obs), 32'h4000);
      @(negedge clock);
      rst = 1'b1;
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "idle_after_reset");

      q.push_back({1'b1, 8'h41});
      run(8, 0, 400, "data41");
      chk("data41_done", n_done, 1);
      chk("data41_epulses", n_epulse, 1);
      chk("data41_dis", n_dis, 1);
      chk("data41_ticks", last_wt, 14);
      chk("data41_bus", {LCD_RS, LCD_DATA}, {1'b1, 8'h41});

      lens[0] = 8'h01; lens[1] = 8'h03; lens[2] = 8'h04;
      for (int i = 0; i < 3; i++) begin
         q.push_back({1'b0, lens[i]});
         run(0, 0, 3000, "cmd_len");
         chk("cmd_len_ticks", last_wt, (lens[i] == 8'h04) ? 14 : 414);
         chk("cmd_len_done", n_done, 1);
      end

      q.push_back({1'b0, 8'h38});
      q.push_back({1'b0, 8'h0C});
      run(0, 0, 200, "b2b");
      chk("b2b_done", n_done, 2);
      chk("b2b_epulses", n_epulse, 2);

      q.push_back({1'b1, 8'h55});
      run(3, 1, 200, "abort_e");
      chk("abort_e_done", n_done, 0);
      chk("abort_e_dis", n_dis, 1);

      cycle(1'b1, 1'b1, 8'h66, 1'b1, 1'b1, "idle_abort");
      chk("idle_abort_ready", 32'(ReqReady), 32'd1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "idle_abort_after");

      q.push_back({1'b1, 8'h42});
      run(1, 2, 200, "stray_req");
      chk("stray_req_done", n_done, 1);
      chk("stray_req_data", 32'(LCD_DATA), 32'h42);

      for (int i = 0; i < 4000; i++) begin
         logic [7:0] d;
         d = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
         cycle($urandom_range(0, 3) == 0, 1'($urandom), d, $urandom_range(0, 63) == 0,
               1'($urandom_range(0, 1)), "random");
      end

      q.push_back({1'b1, 8'h77});
      cyc = 0;
      while (!(m_busy && m_t >= S && m_t < S + E) && cyc < 100) begin
         if (q.size() > 0) cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, "to_ehigh");
         else              cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "to_ehigh");
         if (m_acc) void'(q.pop_front());
         cyc++;
      end
      chk("reach_ehigh", 32'(LCD_E), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_reset_e", 32'(LCD_E), 32'd0);
      chk("async_reset_outputs", 32'(obs), 32'h4000);
      m_busy = 1'b0; m_t = 0; m_rs = 1'b0; m_data = 8'h00; m_dis = 1'b0; m_done = 1'b0;
      ReqValid = 1'b0; TimerTick = 1'b0;
      @(negedge clock);
      rst = 1'b1;
      n_done = 0;
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "post_reset");
      chk("post_reset_ready", 32'(ReqReady), 32'd1);
      chk("post_reset_no_done", n_done, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
